// File: rtl/rst_req_responder.sv
// Responder side of the reset request/acknowledge handshake: stalls and drains
// local traffic, acknowledges, then holds the local domain in reset before release.
module rst_req_responder #(
  parameter int HOLD_CYCLES   = 4,
  parameter int CNT_W         = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             irstn,
  input  logic             ireq,
  output logic             oack,
  input  logic             iissue,
  input  logic             idone,
  output logic             ostall,
  output logic             olocal_rstn,
  output logic             oready,
  output logic             otimeout,
  output logic [CNT_W-1:0] ooutstanding
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, ACK} state_t;

  state_t           state, state_nxt;
  logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic             timeout_nxt;
  logic             lrstn_nxt, stall_nxt, ready_nxt, ack_nxt;
  logic             issue_ok, done_ok;
  logic [CNT_W-1:0] cnt_nxt;

  // Next-state logic for the handshake FSM and its hold/timeout counters
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    timeout_nxt  = otimeout;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (ireq) begin
          state_nxt   = DRAIN;
          tmo_cnt_nxt = {TW{1'b0}};
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        // A dropped request aborts the drain before any completion check.
        if (!ireq) begin
          state_nxt = RUN;
        end else if (ooutstanding == CNT_ZERO) begin
          state_nxt = ACK;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt   = ACK;
          timeout_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
      ACK: begin
        if (!ireq) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = {HW{1'b0}};
        end else begin
          state_nxt = ACK;
        end
      end
      default: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = {HW{1'b0}};
      end
    endcase
  end

  // Output values decoded from the next state so the registered outputs track the FSM
  always_comb begin
    lrstn_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
    stall_nxt = (state_nxt != RUN);
    ready_nxt = (state_nxt == RUN);
    ack_nxt   = (state_nxt == ACK);
  end

  // Outstanding-transaction counter update with saturation and reset clearing
  always_comb begin
    issue_ok = iissue && !ostall && (ooutstanding != CNT_MAX);
    done_ok  = idone && (ooutstanding != CNT_ZERO);
    if (!lrstn_nxt) begin
      cnt_nxt = CNT_ZERO;
    end else if (issue_ok && !done_ok) begin
      cnt_nxt = ooutstanding + 1'b1;
    end else if (done_ok && !issue_ok) begin
      cnt_nxt = ooutstanding - 1'b1;
    end else begin
      cnt_nxt = ooutstanding;
    end
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge irstn) begin
    if (!irstn) begin
      state        <= HOLD;
      hold_cnt     <= {HW{1'b0}};
      tmo_cnt      <= {TW{1'b0}};
      olocal_rstn  <= 1'b0;
      oready       <= 1'b0;
      oack         <= 1'b0;
      ostall       <= 1'b1;
      otimeout     <= 1'b0;
      ooutstanding <= CNT_ZERO;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      olocal_rstn  <= lrstn_nxt;
      oready       <= ready_nxt;
      oack         <= ack_nxt;
      ostall       <= stall_nxt;
      otimeout     <= timeout_nxt;
      ooutstanding <= cnt_nxt;
    end
  end

endmodule
